// File: rtl/req_capture_encoder.sv
// Captures rising edges on asynchronous request lines, arbitrates them by fixed
// priority (highest index wins) and presents one binary-encoded event at a time.
module req_capture_encoder #(
    parameter int WIDTH       = 8,
    parameter int IDX_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic [WIDTH-1:0] mask,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [IDX_W-1:0] code,
    output logic [WIDTH-1:0] pending,
    output logic             overflow,
    input  logic             clear_ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESENT = 2'b01
    } state_t;

    state_t state;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] eligible;
    logic [IDX_W-1:0] winner;
    logic             any_eligible;
    logic             load;
    logic [WIDTH-1:0] take;
    logic [WIDTH-1:0] pending_next;
    logic             ovf_set;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    function automatic logic [IDX_W-1:0] top_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        edge_det     = sync_q[SYNC_STAGES-1] & ~prev_q;
        eligible     = pending & mask;
        any_eligible = |eligible;
        winner       = top_index(eligible);
        load         = 1'b0;
        case (state)
            IDLE:    load = any_eligible;
            PRESENT: load = any_eligible & code_ready;
            default: load = 1'b0;
        endcase
        take         = load ? (WIDTH'(1) << winner) : '0;
        // A fresh edge on a bit being taken this cycle re-pends it (set wins).
        pending_next = edge_det | (pending & ~take);
        ovf_set      = |(edge_det & pending & ~take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= ovf_set | (overflow & ~clear_ovf);
        end
    end

    // Output register: code and code_valid come only from these flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            code_valid <= 1'b0;
            code       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        code       <= winner;
                        code_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (code_ready) begin
                        if (any_eligible) begin
                            code       <= winner;
                            code_valid <= 1'b1;
                        end else begin
                            code_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    code_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/req_capture_encoder.md
Name: req_capture_encoder

Overview:
- Captures rising edges on 8 asynchronous request lines into a pending register.
- Arbitrates the pending requests by fixed priority, highest index wins.
- Presents the winning 3-bit index with a valid/ready handshake.
- Sits upstream of the one-hot-to-binary encoder path. It supplies registered, one-at-a-time encoded events to downstream consumers. Sticky overflow reporting covers lost events.

Parameters:
- WIDTH, 8, number of request lines.
- IDX_W, 3, code width; must equal clog2(WIDTH).
- SYNC_STAGES, 2, synchronizer depth per request line (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  WIDTH  asynchronous level request lines; each rising edge is one event.
- mask  input  WIDTH  synchronous enable per line; 1 = eligible for presentation.
- code_valid  output  1  code holds a valid event.
- code_ready  input  1  consumer accepts code this cycle.
- code  output  IDX_W  binary index of the presented event.
- pending  output  WIDTH  latched, not-yet-presented events.
- overflow  output  1  sticky flag: an event was lost.
- clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - code_valid=0, code=0, pending=0, overflow=0.
  - All synchronizer and edge-history flops are cleared to 0. A line already high at reset release therefore counts as one event.
- Synchronizer and edge detection:
  - Each line passes SYNC_STAGES flops.
  - edge[i] = sync_out[i] & ~prev[i], where prev is one further flop.
- Pending update, every clock, per bit:
  - next pending[i] = edge[i] | (pending[i] & ~take[i]).
  - take[i] is high when bit i is loaded into the output register this cycle.
  - If set and clear hit the same bit in the same cycle, set wins.
- Overflow:
  - Sets when edge[i] & pending[i] & ~take[i] for any i. A new event hit a bit still waiting, so the event is lost.
  - An edge on the bit currently held in code is not overflow. It re-pends normally.
  - clear_ovf clears overflow. If clear_ovf and a new overflow condition occur in the same cycle, set wins.
- Eligible set: E = pending & mask.
  - Masked bits still latch into pending and can overflow; they are never presented.
  - Unmasking presents them in normal priority order.
- Priority: the highest set index in E wins. E=8'b1001_0000 gives code 7.
- States:
  - IDLE (code_valid=0):
    - If E is nonzero, load the winner into code, pulse take, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT (code_valid=1):
    - code is held stable while code_ready=0.
    - On code_valid & code_ready with E nonzero: load the next winner in the same cycle. code_valid stays 1, giving back-to-back throughput of one event per clock.
    - On code_valid & code_ready with E zero: go to IDLE, code_valid=0. code keeps its last value.
  - Any other state decodes to IDLE.
- Latency:
  - With SYNC_STAGES=2 and the pipeline idle, a req_in rise just before clock edge E0 sets pending after E2.
  - code_valid rises after E3.
  - General case: SYNC_STAGES+2 clocks.
- Output-register rules:
  - code and code_valid come straight from flops; no combinational path from req_in or code_ready.
  - code_ready while code_valid=0 has no effect.
- Mask changes while PRESENT do not retract the presented code.
- Reset mid-operation: the in-flight code and all pending events are discarded. No event is reported after release unless a line is high or newly rises.

Test Plan:
- Single event: reset, code_ready=1, mask=8'hFF, pulse req_in[4] -> code_valid=1 for 1 clk with code=3'd4 exactly 4 clocks after the rise; pending returns to 0.
- Priority plus back-to-back: raise req_in[1], [4] and [7] in the same cycle, code_ready=1 -> codes 7, 4, 1 on consecutive clocks with code_valid high for 3 clocks.
- Backpressure: code_ready=0, events on bits 2 and 6 -> code=6 held stable 10+ clocks. Then code_ready=1 -> 6 then 2, then code_valid=0.
- Mask: mask=8'h7F, event on bit 7 -> pending=8'h80, code_valid stays 0. Set mask=8'hFF -> code=7 presented.
- Overflow: code_ready=0, code=5 held. Two rising edges on bit 3 -> overflow=1, pending[3]=1. A third edge on bit 5 -> pending[5]=1 with no overflow. clear_ovf -> overflow=0.
- Reset mid-operation: code_valid=1 and pending=8'h12, assert rst_n=0 asynchronously between clock edges -> code_valid, code, pending and overflow go to 0 immediately. With req_in=0 at release, no event follows.
